im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Write-side counterpart of the instruction fetch unit: streams a program into the 1024-word instruction memory that the fetch unit reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one write per word into the instruction memory write port.
- Holds the CPU in reset while loading, so fetch restarts at the boot PC once the load completes.

Parameters:
- ADDR_W, 10, word-address width of instruction memory (depth 2^ADDR_W words).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- word_cnt  input  ADDR_W+1  number of words to load; sampled on the accepted start.
- byte_in  input  8  program byte, MSB-first within each word.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction memory write enable, one-cycle pulse per word.
- im_waddr  output  ADDR_W  word index being written (memory word 0 corresponds to PC 0x00003000).
- im_wdata  output  32  assembled instruction word.
- cpu_rst  output  1  hold-in-reset request to the CPU (ORed with rst at top level).
- busy  output  1  high in LOAD or WRITE.
- done  output  1  high in DONE.
- err  output  1  word_cnt exceeded memory depth on the last accepted start.
- words_loaded  output  ADDR_W+1  count of words written since the last accepted start.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; byte index, word index and words_loaded cleared to 0; shift register cleared to 0.
  - Outputs: err=0, im_we=0, byte_ready=0, cpu_rst=0, busy=0, done=0; im_waddr=0, im_wdata=0.
- Reset mid-load:
  - Abandons the load immediately; the partial word is discarded.
  - No write is issued in the reset cycle or after it.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE / DONE, on start=1:
  - Latch word_cnt into cnt_q; clear err, words_loaded, byte index and word index.
  - If cnt_q==0: go to DONE (no writes, cpu_rst never asserted).
  - If cnt_q > 2^ADDR_W: set err=1, go to DONE, no writes.
  - Otherwise go to LOAD.
- LOAD:
  - byte_ready=1 (registered-state decode, no combinational path from byte_valid).
  - A byte is transferred when byte_valid & byte_ready; it is shifted in as shreg <= {shreg[23:0], byte_in}, and byte index increments modulo 4.
  - On the 4th transferred byte (index 3), go to WRITE.
  - byte_valid=0 means stall; state is held indefinitely.
- WRITE (exactly one cycle):
  - byte_ready=0, im_we=1, im_waddr=word index, im_wdata=shreg.
  - At the posedge: word index +1, words_loaded +1.
  - If words_loaded+1 == cnt_q, go to DONE; else go to LOAD.
- DONE:
  - done=1, held until the next accepted start or rst.
- Outputs:
  - cpu_rst = busy = (state==LOAD || state==WRITE); CPU pc is therefore forced to boot PC throughout.
  - cpu_rst deasserts in the first DONE cycle, so the CPU fetches word 0 on the following cycle.
  - im_waddr and im_wdata hold their last values outside WRITE; im_we=0 outside WRITE.
- start in LOAD/WRITE is ignored.
- start in the same cycle as rst: rst wins.
- Throughput: minimum 5 cycles per word (4 byte transfers + 1 write).
- Wrap: cnt_q == 2^ADDR_W writes indices 0..2^ADDR_W-1; the word index never wraps within one load.

Test Plan:
- Reset, then start with word_cnt=2 and continuous valid bytes 8C,01,00,04,00,00,00,0C:
  - im_we pulses exactly twice, 5 cycles apart.
  - Writes are (0, 0x8C010004) and (1, 0x0000000C).
  - done rises in the cycle after the 2nd write; words_loaded=2; cpu_rst high from the cycle after start until done.
- word_cnt=1 with byte_valid toggling 1,0,0,1,0,1,1:
  - Exactly 4 bytes are accepted; bytes are not consumed during gaps.
  - A single write of the assembled word at index 0.
- word_cnt=0: done=1 one cycle after start; no im_we; cpu_rst stays 0; err=0.
- word_cnt=1025 (ADDR_W=10):
  - done=1 and err=1, no writes.
  - A subsequent start with word_cnt=1 clears err and loads normally.
- rst asserted after 2 bytes of word 3 of 5:
  - Next cycle: state IDLE, busy=0, cpu_rst=0, words_loaded=0, done=0, no im_we.
  - A new start reloads from index 0.
- start pulsed during LOAD is ignored: cnt_q is unchanged and the load completes with the original count.

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream loader bus: program byte handshake, load control/status and
// the instruction memory write port, bundled between driver and loader.
interface im_loader_if #(
  parameter int ADDR_W = 10
) ();

  // load control
  logic              start;
  logic [ADDR_W:0]   word_cnt;

  // byte stream
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;

  // instruction memory write port
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;

  // status
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  // The side that sources bytes and commands loads.
  modport master (
    output start, word_cnt, byte_in, byte_valid,
    input  byte_ready, im_we, im_waddr, im_wdata,
    input  cpu_rst, busy, done, err, words_loaded
  );

  // The loader itself.
  modport slave (
    input  start, word_cnt, byte_in, byte_valid,
    output byte_ready, im_we, im_waddr, im_wdata,
    output cpu_rst, busy, done, err, words_loaded
  );

endinterface

// File: rtl/im_loader.sv
// Instruction memory loader: assembles a big-endian byte stream into 32-bit
// words and writes them into the instruction memory, holding the CPU in
// reset for the duration of the load so fetch restarts at the boot PC.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no load since reset; waiting for start
// S_LOAD  | accepting bytes of the current word (byte_ready high)
// S_WRITE | one-cycle write of the assembled word into memory
// S_DONE  | load finished or rejected; waiting for the next start
module im_loader #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  im_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest legal word count: one full memory, 2^ADDR_W words.
  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] WIDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W-1:0] widx_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        bidx_q;
  logic [31:0]       shreg_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              start_ok;
  logic              xfer;
  logic              last_byte;
  logic              cnt_zero;
  logic              cnt_over;
  logic [ADDR_W:0]   words_inc;
  logic [31:0]       shreg_nxt;

  // start is only honoured when no load is in flight
  assign start_ok  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // byte_ready is a pure state decode, so a transfer is valid & LOAD
  assign xfer      = bus.byte_valid && (state_q == S_LOAD);
  assign last_byte = xfer && (bidx_q == 2'd3);
  assign cnt_zero  = (bus.word_cnt == '0);
  assign cnt_over  = (bus.word_cnt > DEPTH);
  assign words_inc = words_q + CNT_ONE;
  assign shreg_nxt = {shreg_q[23:0], bus.byte_in};

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          if (cnt_zero || cnt_over) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (last_byte) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (words_inc == cnt_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load bookkeeping: latched count, error flag and progress counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
      widx_q  <= '0;
      bidx_q  <= 2'd0;
    end else begin
      if (start_ok) begin
        cnt_q   <= bus.word_cnt;
        err_q   <= cnt_over;
        words_q <= '0;
        widx_q  <= '0;
        bidx_q  <= 2'd0;
      end
      if (xfer) begin
        bidx_q <= bidx_q + 2'd1;
      end
      // the index wraps only after the last word of a full-memory load,
      // where it is never used again
      if (state_q == S_WRITE) begin
        widx_q  <= widx_q + WIDX_ONE;
        words_q <= words_inc;
      end
    end
  end

  // Byte assembly, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (xfer) begin
      shreg_q <= shreg_nxt;
    end
  end

  // Write-port address/data are captured with the word's final byte so they
  // are valid throughout WRITE and hold their last value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (last_byte) begin
      waddr_q <= widx_q;
      wdata_q <= shreg_nxt;
    end
  end

  assign bus.byte_ready   = (state_q == S_LOAD);
  assign bus.im_we        = (state_q == S_WRITE);
  assign bus.im_waddr     = waddr_q;
  assign bus.im_wdata     = wdata_q;
  assign bus.busy         = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.cpu_rst      = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.err          = err_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: expected memory writes are queued as bytes are
// staged and checked as the loader pulses im_we; timing and status are
// checked against cycle numbers recorded on the falling edge.
module tb_im_loader;

  localparam int ADDR_W = 10;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  wr_t        sb[$];
  wr_t        mon_e;
  logic [7:0] byte_q[$];
  bit         pat_q[$];
  int         mid_at = -1;

  int   cyc = 0;
  int   start_cyc = 0;
  int   we_cnt, acc_cnt, cpu_hi_cnt;
  int   done_rise, cpu_rise, cpu_fall;
  int   we_cyc[$];
  logic done_prev = 1'b0;
  logic cpu_prev  = 1'b0;
  logic err_after_start;

  // falling-edge monitor: handshake accounting, edge timestamps, write checks
  always @(negedge clk) begin
    cyc++;
    if (bus.byte_valid && bus.byte_ready) acc_cnt++;
    if (bus.cpu_rst) cpu_hi_cnt++;
    if (bus.cpu_rst && !cpu_prev) cpu_rise = cyc;
    if (!bus.cpu_rst && cpu_prev) cpu_fall = cyc;
    if (bus.done && !done_prev) done_rise = cyc;
    cpu_prev  = bus.cpu_rst;
    done_prev = bus.done;
    if (bus.im_we) begin
      we_cnt++;
      we_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("waddr", bus.im_waddr, mon_e.addr);
        check("wdata", bus.im_wdata, mon_e.data);
      end
    end
  end

  task automatic clear_mon();
    we_cnt     = 0;
    acc_cnt    = 0;
    cpu_hi_cnt = 0;
    done_rise  = -1;
    cpu_rise   = -1;
    cpu_fall   = -1;
    we_cyc.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic rand_bytes(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
  endtask

  // expected writes for the first nwords words of byte_q, from index 0
  task automatic push_words(input int nwords);
    wr_t e;
    for (int w = 0; w < nwords; w++) begin
      e.addr = ADDR_W'(w);
      e.data = {byte_q[4*w], byte_q[4*w+1], byte_q[4*w+2], byte_q[4*w+3]};
      sb.push_back(e);
    end
  endtask

  // one-cycle start pulse; returns at the start of the following cycle
  task automatic do_start(input int cnt);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.word_cnt = (ADDR_W+1)'(cnt);
    start_cyc    = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // start a load and feed every byte of byte_q, valid shaped by pat_q
  task automatic run_load(input int cnt, input int budget);
    int idx;
    int pi;
    int n;
    bit acc;
    bit mid_done;
    idx = 0; pi = 0; n = 0; mid_done = 0;
    do_start(cnt);
    err_after_start = bus.err;
    while (idx < byte_q.size() && n < budget) begin
      bus.byte_in    = byte_q[idx];
      bus.byte_valid = (pi < pat_q.size()) ? pat_q[pi] : 1'b1;
      if (idx == mid_at && !mid_done) begin
        bus.start    = 1'b1;
        bus.word_cnt = (ADDR_W+1)'(7);
        mid_done     = 1'b1;
      end
      acc = bus.byte_valid && bus.byte_ready;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (acc) idx++;
      pi++;
      n++;
    end
    bus.byte_valid = 1'b0;
    check("feed_in_budget", n < budget, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_reached", bus.done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bus.start      = 1'b0;
    bus.word_cnt   = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    clear_mon();

    // reset state
    apply_reset();
    check("rst_err",        bus.err, 0);
    check("rst_im_we",      bus.im_we, 0);
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_cpu_rst",    bus.cpu_rst, 0);
    check("rst_busy",       bus.busy, 0);
    check("rst_done",       bus.done, 0);
    check("rst_waddr",      bus.im_waddr, 0);
    check("rst_wdata",      bus.im_wdata, 0);
    check("rst_words",      bus.words_loaded, 0);

    // two words, continuous stream
    clear_mon();
    byte_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0C};
    push_words(2);
    run_load(2, 100);
    wait_done(50);
    repeat (2) begin @(posedge clk); #1; end
    check("t1_we_cnt",   we_cnt, 2);
    check("t1_cpu_rise", cpu_rise, start_cyc + 1);
    d = (we_cyc.size() >= 1) ? we_cyc[0] : -1;
    check("t1_first_we", d, start_cyc + 5);
    d = (we_cyc.size() >= 2) ? (we_cyc[1] - we_cyc[0]) : -1;
    check("t1_we_spacing", d, 5);
    d = (we_cyc.size() >= 2) ? we_cyc[1] + 1 : -1;
    check("t1_done_rise", done_rise, d);
    check("t1_cpu_fall",  cpu_fall, done_rise);
    check("t1_words",     bus.words_loaded, 2);
    check("t1_err",       bus.err, 0);

    // one word with gaps in byte_valid; ready must stay low after the word
    clear_mon();
    byte_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    pat_q  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    push_words(1);
    run_load(1, 50);
    pat_q.delete();
    bus.byte_in    = 8'hFF;
    bus.byte_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b0;
    check("t2_acc_cnt", acc_cnt, 4);
    check("t2_we_cnt",  we_cnt, 1);
    check("t2_done",    bus.done, 1);
    check("t2_words",   bus.words_loaded, 1);

    // zero-length load
    apply_reset();
    clear_mon();
    do_start(0);
    check("t3_done", bus.done, 1);
    check("t3_err",  bus.err, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t3_we_cnt",  we_cnt, 0);
    check("t3_cpu_hi",  cpu_hi_cnt, 0);
    check("t3_words",   bus.words_loaded, 0);

    // oversized load is rejected, next load clears err
    apply_reset();
    clear_mon();
    do_start(1025);
    check("t4_done", bus.done, 1);
    check("t4_err",  bus.err, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_we_cnt", we_cnt, 0);
    check("t4_cpu_hi", cpu_hi_cnt, 0);
    clear_mon();
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_words(1);
    run_load(1, 50);
    check("t4_err_cleared", err_after_start, 0);
    wait_done(50);
    repeat (2) begin @(posedge clk); #1; end
    check("t4_reload_we", we_cnt, 1);
    check("t4_err_after", bus.err, 0);
    check("t4_words",     bus.words_loaded, 1);

    // reset after 2 bytes of the third of five words
    apply_reset();
    clear_mon();
    rand_bytes(10);
    push_words(2);
    run_load(5, 100);
    check("t5_words_pre", bus.words_loaded, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_busy",    bus.busy, 0);
    check("t5_cpu_rst", bus.cpu_rst, 0);
    check("t5_words",   bus.words_loaded, 0);
    check("t5_done",    bus.done, 0);
    check("t5_im_we",   bus.im_we, 0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("t5_we_cnt", we_cnt, 2);
    check("t5_sb_drained", sb.size(), 0);
    clear_mon();
    rand_bytes(4);
    push_words(1);
    run_load(1, 50);
    wait_done(50);
    repeat (2) begin @(posedge clk); #1; end
    check("t5_reload_we", we_cnt, 1);

    // start during LOAD is ignored
    apply_reset();
    clear_mon();
    rand_bytes(8);
    push_words(2);
    mid_at = 3;
    run_load(2, 100);
    mid_at = -1;
    wait_done(50);
    repeat (5) begin @(posedge clk); #1; end
    check("t6_we_cnt", we_cnt, 2);
    check("t6_words",  bus.words_loaded, 2);
    check("t6_done",   bus.done, 1);
    check("t6_busy",   bus.busy, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
